// File: rtl/fpu_ex_scheduler.sv
// EX-stage sequencer for multi-cycle FPU operations: launches the FPU, holds the
// front of the pipeline and bubbles EX->MEM until the result is due, then steers it in.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no FP op in flight; a multi-cycle op in EX launches here
//   ST_RUN  | FPU computing; pipeline held, bubbles into EX->MEM
//   ST_DONE | FPU result due; steered into EX->MEM until MEM accepts it
module fpu_ex_scheduler #(
    parameter int ADD_LAT  = 3,
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 16,
    parameter int SQRT_LAT = 20,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid_E,
    input  logic [2:0]  fpu_op_E,
    input  logic        mem_stall,
    input  logic        kill,
    output logic        fpu_start,
    output logic        fpu_abort,
    output logic        fpu_ack,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        bubble_M,
    output logic        result_sel_M,
    output logic        busy,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ADD_INIT  = CNT_W'(ADD_LAT - 2);
    localparam logic [CNT_W-1:0] MUL_INIT  = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_LAT - 2);
    localparam logic [CNT_W-1:0] SQRT_INIT = CNT_W'(SQRT_LAT - 2);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] lat_init;
    logic             mc;
    logic             start_c, abort_c, ack_c, stall_c, bubble_c, sel_c;

    always_comb begin
        mc       = 1'b0;
        lat_init = '0;
        case (fpu_op_E)
            3'b010:  begin mc = issue_valid_E; lat_init = ADD_INIT;  end
            3'b011:  begin mc = issue_valid_E; lat_init = MUL_INIT;  end
            3'b100:  begin mc = issue_valid_E; lat_init = DIV_INIT;  end
            3'b101:  begin mc = issue_valid_E; lat_init = SQRT_INIT; end
            default: begin mc = 1'b0;          lat_init = '0;        end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start_c   = 1'b0;
        abort_c   = 1'b0;
        ack_c     = 1'b0;
        stall_c   = 1'b0;
        bubble_c  = 1'b0;
        sel_c     = 1'b0;
        if (kill) begin
            abort_c   = (state != ST_IDLE);
            bubble_c  = 1'b1;
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mc && !mem_stall) begin
                        start_c   = 1'b1;
                        stall_c   = 1'b1;
                        bubble_c  = 1'b1;
                        cnt_nxt   = lat_init;
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The FPU keeps running under MEM backpressure, so count regardless.
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (cnt == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    sel_c = 1'b1;
                    if (!mem_stall) begin
                        ack_c     = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Mealy outputs are gated so everything reads 0 while reset is held.
    assign fpu_start    = reset & start_c;
    assign fpu_abort    = reset & abort_c;
    assign fpu_ack      = reset & ack_c;
    assign stall_F      = reset & stall_c;
    assign stall_D      = reset & stall_c;
    assign stall_E      = reset & stall_c;
    assign bubble_M     = reset & bubble_c;
    assign result_sel_M = reset & sel_c;
    assign busy         = reset & (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (stall_E) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fpu_ex_scheduler.sv
// Bench for fpu_ex_scheduler: directed scenarios plus random traffic, all checked
// against a timestamp-based model of when each FP result falls due.
module tb_fpu_ex_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid_E;
    logic [2:0]  fpu_op_E;
    logic        mem_stall;
    logic        kill;
    logic        fpu_start, fpu_abort, fpu_ack;
    logic        stall_F, stall_D, stall_E;
    logic        bubble_M, result_sel_M, busy;
    logic [31:0] stall_count;

    int          n_tests = 0;
    int          n_fail  = 0;

    // model: one op in flight at most, result due at an absolute cycle number
    int          cyc       = 0;
    bit          m_active  = 1'b0;
    int          m_due     = 0;
    logic [31:0] m_count   = '0;

    fpu_ex_scheduler dut (
        .clk(clk), .reset(reset), .issue_valid_E(issue_valid_E), .fpu_op_E(fpu_op_E),
        .mem_stall(mem_stall), .kill(kill), .fpu_start(fpu_start), .fpu_abort(fpu_abort),
        .fpu_ack(fpu_ack), .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
        .bubble_M(bubble_M), .result_sel_M(result_sel_M), .busy(busy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input logic [2:0] op);
        case (op)
            3'b010:  return 3;
            3'b011:  return 4;
            3'b100:  return 16;
            3'b101:  return 20;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 32'(fpu_start), 0);
        chk({tag, "_abort"}, 32'(fpu_abort), 0);
        chk({tag, "_ack"}, 32'(fpu_ack), 0);
        chk({tag, "_stall"}, {29'd0, stall_F, stall_D, stall_E}, 0);
        chk({tag, "_bubble"}, 32'(bubble_M), 0);
        chk({tag, "_sel"}, 32'(result_sel_M), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_count"}, stall_count, 0);
    endtask

    // One pipeline cycle: drive inputs after the falling edge, check before the rising edge.
    task automatic step(input logic iv, input logic [2:0] op, input logic ms, input logic kl);
        logic e_start, e_abort, e_ack, e_stall, e_bub, e_sel;
        bit   nxt_active;
        int   lat;
        @(negedge clk);
        issue_valid_E = iv;
        fpu_op_E      = op;
        mem_stall     = ms;
        kill          = kl;
        #1;
        {e_start, e_abort, e_ack, e_stall, e_bub, e_sel} = '0;
        nxt_active = m_active;
        lat = lat_of(op);
        if (kl) begin
            e_abort    = m_active;
            e_bub      = 1'b1;
            nxt_active = 1'b0;
        end else if (!m_active) begin
            if (iv && lat > 0 && !ms) begin
                e_start = 1'b1; e_stall = 1'b1; e_bub = 1'b1;
                nxt_active = 1'b1;
                m_due = cyc + lat;
            end
        end else if (cyc < m_due) begin
            e_stall = 1'b1; e_bub = 1'b1;
        end else begin
            e_sel = 1'b1;
            if (!ms) begin
                e_ack = 1'b1;
                nxt_active = 1'b0;
            end
        end
        chk("start", 32'(fpu_start), 32'(e_start));
        chk("abort", 32'(fpu_abort), 32'(e_abort));
        chk("ack", 32'(fpu_ack), 32'(e_ack));
        chk("stall_F", 32'(stall_F), 32'(e_stall));
        chk("stall_D", 32'(stall_D), 32'(e_stall));
        chk("stall_E", 32'(stall_E), 32'(e_stall));
        chk("bubble_M", 32'(bubble_M), 32'(e_bub));
        chk("result_sel_M", 32'(result_sel_M), 32'(e_sel));
        chk("busy", 32'(busy), 32'(m_active));
        chk("stall_count", stall_count, m_count);
        if (e_stall) m_count = m_count + 32'd1;
        m_active = nxt_active;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        issue_valid_E = 1'b1; fpu_op_E = 3'b100; mem_stall = 1'b0; kill = 1'b0;
        #1;
        chk_all_zero("rst");
        @(negedge clk);
        reset = 1'b1;
        issue_valid_E = 1'b0; fpu_op_E = 3'b000;
        m_active = 1'b0;
        m_count  = '0;
    endtask

    initial begin
        reset = 1'b0; issue_valid_E = 1'b0; fpu_op_E = 3'b000; mem_stall = 1'b0; kill = 1'b0;
        do_reset();

        // single-cycle and none ops never stall
        step(1, 3'b000, 0, 0);
        step(1, 3'b001, 0, 0);
        step(1, 3'b110, 0, 0);
        step(1, 3'b111, 0, 0);
        step(0, 3'b000, 0, 0);
        chk("t1_count", stall_count, 0);

        // fdiv: 16 stall cycles, result accepted at t+16
        do_reset();
        step(1, 3'b100, 0, 0);
        chk("t2_start", 32'(fpu_start), 1);
        for (int i = 1; i < 16; i++) step(1, 3'b100, 0, 0);
        step(1, 3'b100, 0, 0);
        chk("t2_ack", 32'(fpu_ack), 1);
        chk("t2_sel", 32'(result_sel_M), 1);
        step(0, 3'b000, 0, 0);
        chk("t2_count", stall_count, 16);

        // fmul with MEM backpressure over the result cycle
        do_reset();
        step(1, 3'b011, 0, 0);
        for (int i = 1; i < 4; i++) step(1, 3'b011, 0, 0);
        for (int i = 4; i < 7; i++) step(1, 3'b011, 1, 0);
        step(1, 3'b011, 0, 0);
        chk("t3_ack", 32'(fpu_ack), 1);
        step(0, 3'b000, 0, 0);
        chk("t3_idle", 32'(busy), 0);

        // fdiv killed mid-run
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 3'b100, 0, 0);
        step(1, 3'b100, 0, 1);
        chk("t4_abort", 32'(fpu_abort), 1);
        chk("t4_bubble", 32'(bubble_M), 1);
        chk("t4_stall", 32'(stall_E), 0);
        step(0, 3'b000, 0, 0);
        chk("t4_idle", 32'(busy), 0);

        // async reset between edges while running
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 3'b101, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("t5_async");
        @(negedge clk);
        reset = 1'b1;
        issue_valid_E = 1'b0;
        m_active = 1'b0;
        m_count  = '0;
        step(0, 3'b000, 0, 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_count", stall_count, 0);

        // back-to-back fadd
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 3'b010, 0, 0);
        step(0, 3'b000, 0, 0);
        chk("t6_count", stall_count, 6);

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
